mips_multicycle_core: RTL

Multi-cycle MIPS32 core; next generation of the team's single-cycle CPU. Replaces the separate instruction/data memories with one shared memory port using a req/ready handshake, so instruction and data access take variable latency. Sequenced by an FSM with internal IR/MDR/A/B/ALUOut registers and its own 32x32 register file. Sits between the testbench/top-level and a unified memory model.

---
 rtl/mips_multicycle_core.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32 core with a single shared memory port (req/ready).
// Supports add/sub/and/or/slt, addi, lw, sw, beq and j.
// Optional feature macro: PERF_CNT_EN adds cycle_count and instret_count outputs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | read instruction at PC; on ready latch IR and advance PC
// S_DECODE | read rs/rt into A/B, precompute branch target into ALUOut
// S_EXEC   | ALU operation, or resolve beq/j and retire
// S_MEM    | lw/sw data access at ALUOut; misaligned address halts
// S_WB     | write ALUOut or MDR to the destination GPR and retire
// S_HALT   | bus idle, halted=1; only reset leaves this state
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        retire
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] alu_out;
    logic [31:0] gpr [32];

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic        op_r;
    logic        op_addi;
    logic        op_lw;
    logic        op_sw;
    logic        op_beq;
    logic        op_j;
    logic        funct_ok;
    logic        legal;
    logic [4:0]  wb_dst;
    logic [31:0] alu_res;
    logic        mem_done;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    assign op_r     = (opcode == 6'h00);
    assign op_addi  = (opcode == 6'h08);
    assign op_lw    = (opcode == 6'h23);
    assign op_sw    = (opcode == 6'h2B);
    assign op_beq   = (opcode == 6'h04);
    assign op_j     = (opcode == 6'h02);
    assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                      (funct == 6'h25) || (funct == 6'h2A);
    assign legal    = (op_r && funct_ok) || op_addi || op_lw || op_sw || op_beq || op_j;

    // R-type results go to rd, addi/lw results to rt.
    assign wb_dst   = op_r ? rd : rt;
    assign mem_done = mem_req && mem_ready;

    assign pc_out   = pc;
    assign halted   = (state == S_HALT);

    // ALU: R-type function, otherwise A + sign-extended immediate (addi, lw/sw address).
    always_comb begin
        alu_res = a_reg + imm_sext;
        if (op_r) begin
            case (funct)
                6'h22:   alu_res = a_reg - b_reg;
                6'h24:   alu_res = a_reg & b_reg;
                6'h25:   alu_res = a_reg | b_reg;
                6'h2A:   alu_res = {31'd0, $signed(a_reg) < $signed(b_reg)};
                default: alu_res = a_reg + b_reg;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, bus outputs and retire; the bus is forced idle while reset is held
    // so an in-flight request drops in the same cycle reset asserts.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_next = S_EXEC;
                end else if (HALT_ON_ILLEGAL) begin
                    state_next = S_HALT;
                end else begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                if (op_beq || op_j) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (op_lw || op_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (alu_out[1:0] != 2'b00) begin
                    state_next = S_HALT;
                end else begin
                    mem_req   = 1'b1;
                    mem_we    = op_sw;
                    mem_addr  = alu_out;
                    mem_wdata = op_sw ? b_reg : 32'd0;
                    if (mem_ready) begin
                        if (op_sw) begin
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            state_next = S_WB;
                        end
                    end
                end
            end
            S_WB: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
        if (!reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = 32'd0;
            mem_wdata = 32'd0;
            retire    = 1'b0;
        end
    end

    // Datapath registers and register file, updated according to the current state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            alu_out <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                gpr[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_done) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_reg   <= gpr[rs];
                    b_reg   <= gpr[rt];
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                end
                S_EXEC: begin
                    if (op_beq) begin
                        if (a_reg == b_reg) begin
                            pc <= alu_out;
                        end
                    end else if (op_j) begin
                        pc <= {pc[31:28], ir[25:0], 2'b00};
                    end else begin
                        alu_out <= alu_res;
                    end
                end
                S_MEM: begin
                    if (mem_done && op_lw) begin
                        mdr <= mem_rdata;
                    end
                end
                S_WB: begin
                    // $0 is never written, so it always reads back as zero.
                    if (wb_dst != 5'd0) begin
                        gpr[wb_dst] <= op_lw ? mdr : alu_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    // Free-running cycle counter and retired-instruction counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count   <= 32'd0;
            instret_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (retire) begin
                instret_count <= instret_count + 32'd1;
            end
        end
    end
`endif

endmodule
